// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: decodes 32-bit MIPS32 instruction words into a control
// bundle and buffers the bundles in a small queue. The queue has valid/ready
// handshakes on both sides and a synchronous flush. It sits between fetch and
// the ID/EX register, so an execute stall does not stall fetch immediately.
module ctrl_decode_pipe #(
    parameter int XLEN        = 32,
    parameter int ALUOP_WIDTH = 5,
    parameter int DEPTH       = 2,
    parameter int EN_JTYPE    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_inst,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [ALUOP_WIDTH-1:0] out_alu_op,
    output logic [9:0]             out_ctrl,
    output logic [4:0]             out_rd
);

    // ALU operation codes. These follow the encoding of the shared defines header.
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD      = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB      = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] ALU_MULT     = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] ALU_DIV      = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SL       = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ARITH_SR = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LOGIC_SR = ALUOP_WIDTH'(6);
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND      = ALUOP_WIDTH'(7);
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR       = ALUOP_WIDTH'(8);
    localparam logic [ALUOP_WIDTH-1:0] ALU_XOR      = ALUOP_WIDTH'(9);
    localparam logic [ALUOP_WIDTH-1:0] ALU_NOR      = ALUOP_WIDTH'(10);
    localparam logic [ALUOP_WIDTH-1:0] ALU_L        = ALUOP_WIDTH'(11);
    localparam logic [ALUOP_WIDTH-1:0] ALU_L_U      = ALUOP_WIDTH'(12);
    localparam logic [ALUOP_WIDTH-1:0] ALU_EQ       = ALUOP_WIDTH'(13);
    localparam logic [ALUOP_WIDTH-1:0] ALU_NEQ      = ALUOP_WIDTH'(14);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LE       = ALUOP_WIDTH'(15);
    localparam logic [ALUOP_WIDTH-1:0] ALU_G        = ALUOP_WIDTH'(16);
    localparam logic [ALUOP_WIDTH-1:0] ALU_GE       = ALUOP_WIDTH'(17);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ERR      = '1;

    // A pointer needs at least one bit even when DEPTH is 1.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic [9:0]             ctrl;
        logic [4:0]             rd;
    } entry_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt_f;
    logic [4:0] rd_f;

    assign opcode = in_inst[31:26];
    assign funct  = in_inst[5:0];
    assign rt_f   = in_inst[20:16];
    assign rd_f   = in_inst[15:11];

    logic                   ill, lui, shs, uimm, sext, jmp, br, mw, mr, rw;
    logic [ALUOP_WIDTH-1:0] dec_alu_op;
    logic [4:0]             dec_rd;

    // Combinational decode of the incoming word into the control bundle.
    always_comb begin
        ill = 1'b0; lui = 1'b0; shs = 1'b0; uimm = 1'b0; sext = 1'b0;
        jmp = 1'b0; br = 1'b0; mw = 1'b0; mr = 1'b0; rw = 1'b0;
        dec_alu_op = ALU_ADD;
        dec_rd     = rt_f;
        case (opcode)
            6'h00: begin
                rw     = 1'b1;
                dec_rd = rd_f;
                case (funct)
                    6'h20, 6'h21: dec_alu_op = ALU_ADD;
                    6'h22, 6'h23: dec_alu_op = ALU_SUB;
                    6'h18, 6'h19: begin dec_alu_op = ALU_MULT; rw = 1'b0; end
                    6'h1A, 6'h1B: begin dec_alu_op = ALU_DIV;  rw = 1'b0; end
                    6'h00: begin dec_alu_op = ALU_SL;       shs = 1'b1; end
                    6'h03: begin dec_alu_op = ALU_ARITH_SR; shs = 1'b1; end
                    6'h02: begin dec_alu_op = ALU_LOGIC_SR; shs = 1'b1; end
                    6'h04: dec_alu_op = ALU_SL;
                    6'h07: dec_alu_op = ALU_ARITH_SR;
                    6'h06: dec_alu_op = ALU_LOGIC_SR;
                    6'h24: dec_alu_op = ALU_AND;
                    6'h25: dec_alu_op = ALU_OR;
                    6'h26: dec_alu_op = ALU_XOR;
                    6'h27: dec_alu_op = ALU_NOR;
                    6'h2A: dec_alu_op = ALU_L;
                    6'h2B: dec_alu_op = ALU_L_U;
                    default: ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin dec_alu_op = ALU_ADD; uimm = 1'b1; sext = 1'b1; rw = 1'b1; end
            6'h0A:        begin dec_alu_op = ALU_L;   uimm = 1'b1; sext = 1'b1; rw = 1'b1; end
            6'h0B:        begin dec_alu_op = ALU_L_U; uimm = 1'b1; sext = 1'b1; rw = 1'b1; end
            6'h0C:        begin dec_alu_op = ALU_AND; uimm = 1'b1; rw = 1'b1; end
            6'h0D:        begin dec_alu_op = ALU_OR;  uimm = 1'b1; rw = 1'b1; end
            6'h0E:        begin dec_alu_op = ALU_XOR; uimm = 1'b1; rw = 1'b1; end
            // The shift-by-16 of LUI is implied by the lui bit.
            6'h0F:        begin dec_alu_op = ALU_SL;  lui = 1'b1; uimm = 1'b1; rw = 1'b1; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec_alu_op = ALU_ADD; mr = 1'b1; rw = 1'b1; uimm = 1'b1; sext = 1'b1;
            end
            6'h28, 6'h29, 6'h2B: begin
                dec_alu_op = ALU_ADD; mw = 1'b1; uimm = 1'b1; sext = 1'b1;
            end
            6'h04: begin dec_alu_op = ALU_EQ;  br = 1'b1; sext = 1'b1; end
            6'h05: begin dec_alu_op = ALU_NEQ; br = 1'b1; sext = 1'b1; end
            6'h06: begin dec_alu_op = ALU_LE;  br = 1'b1; sext = 1'b1; end
            6'h07: begin dec_alu_op = ALU_G;   br = 1'b1; sext = 1'b1; end
            6'h01: begin
                br   = 1'b1;
                sext = 1'b1;
                case (rt_f)
                    5'd0:    dec_alu_op = ALU_L;
                    5'd1:    dec_alu_op = ALU_GE;
                    default: ill = 1'b1;
                endcase
            end
            6'h02: begin
                dec_rd = 5'd0;
                if (EN_JTYPE != 0) jmp = 1'b1;
                else               ill = 1'b1;
            end
            6'h03: begin
                if (EN_JTYPE != 0) begin
                    jmp    = 1'b1;
                    rw     = 1'b1;
                    dec_rd = 5'd31;
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        // An illegal word carries only the illegal flag and the error op.
        if (ill) begin
            lui = 1'b0; shs = 1'b0; uimm = 1'b0; sext = 1'b0;
            jmp = 1'b0; br = 1'b0; mw = 1'b0; mr = 1'b0; rw = 1'b0;
            dec_alu_op = ALU_ERR;
            dec_rd     = 5'd0;
        end
    end

    entry_t            entry_q [DEPTH];
    entry_t            entry_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Write the decoded bundle into the tail slot on accept.
    always_comb begin
        entry_d = entry_q;
        if (push) begin
            entry_d[wr_ptr_q].pc     = in_pc;
            entry_d[wr_ptr_q].alu_op = dec_alu_op;
            entry_d[wr_ptr_q].ctrl   = {ill, lui, shs, uimm, sext, jmp, br, mw, mr, rw};
            entry_d[wr_ptr_q].rd     = dec_rd;
        end
    end

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage and control state, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_pc     = entry_q[rd_ptr_q].pc;
    assign out_alu_op = entry_q[rd_ptr_q].alu_op;
    assign out_ctrl   = entry_q[rd_ptr_q].ctrl;
    assign out_rd     = entry_q[rd_ptr_q].rd;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Testbench for ctrl_decode_pipe: directed decode table, hand-written queue
// sequences and randomized traffic against a queue-based reference model.
module tb_ctrl_decode_pipe;

    localparam int DEPTH = 2;

    localparam int A_ADD = 0,  A_SUB = 1,  A_MULT = 2, A_DIV = 3,  A_SL = 4;
    localparam int A_ASR = 5,  A_LSR = 6,  A_AND = 7,  A_OR = 8,   A_XOR = 9;
    localparam int A_NOR = 10, A_L = 11,   A_LU = 12,  A_EQ = 13,  A_NEQ = 14;
    localparam int A_LE = 15,  A_G = 16,   A_GE = 17,  A_ERR = 31;

    localparam int RW = 1, MR = 2, MW = 4, BR = 8, JP = 16;
    localparam int SX = 32, UI = 64, SH = 128, LU = 256, IL = 512;

    localparam int C_NONE = 0, C_R = 1, C_ALUI_S = 2, C_ALUI_Z = 3, C_LUI = 4;
    localparam int C_LOAD = 5, C_STORE = 6, C_BRANCH = 7, C_REGIMM = 8, C_J = 9, C_JAL = 10;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc;
    logic [4:0]  out_alu_op, out_rd;
    logic [9:0]  out_ctrl;

    ctrl_decode_pipe #(.XLEN(32), .ALUOP_WIDTH(5), .DEPTH(DEPTH), .EN_JTYPE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_op(out_alu_op), .out_ctrl(out_ctrl), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [9:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_known;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  alu;
        logic [9:0]  ctrl;
        logic [4:0]  rd;
        logic        rd_known;
    } vec_t;

    exp_t mq[$];
    vec_t vq[$];
    int   checks = 0;
    int   failures = 0;

    int r_alu[64];
    bit r_nw[64];
    bit r_sh[64];
    int i_cls[64];
    int i_alu[64];

    int legal_ops[23] = '{'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0A, 'h0B,
                          'h0C, 'h0D, 'h0E, 'h0F, 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};
    int legal_fn[20]  = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h18, 'h19, 'h1A, 'h1B,
                          'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_r(input int fn, input int alu, input bit nw, input bit sh);
        r_alu[fn] = alu; r_nw[fn] = nw; r_sh[fn] = sh;
    endtask

    task automatic set_i(input int op, input int cls, input int alu);
        i_cls[op] = cls; i_alu[op] = alu;
    endtask

    // Mnemonic tables describing the instruction set.
    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin
            r_alu[k] = -1; r_nw[k] = 0; r_sh[k] = 0; i_cls[k] = C_NONE; i_alu[k] = A_ERR;
        end
        set_r('h20, A_ADD, 0, 0);  set_r('h21, A_ADD, 0, 0);
        set_r('h22, A_SUB, 0, 0);  set_r('h23, A_SUB, 0, 0);
        set_r('h18, A_MULT, 1, 0); set_r('h19, A_MULT, 1, 0);
        set_r('h1A, A_DIV, 1, 0);  set_r('h1B, A_DIV, 1, 0);
        set_r('h00, A_SL, 0, 1);   set_r('h04, A_SL, 0, 0);
        set_r('h03, A_ASR, 0, 1);  set_r('h07, A_ASR, 0, 0);
        set_r('h02, A_LSR, 0, 1);  set_r('h06, A_LSR, 0, 0);
        set_r('h24, A_AND, 0, 0);  set_r('h25, A_OR, 0, 0);
        set_r('h26, A_XOR, 0, 0);  set_r('h27, A_NOR, 0, 0);
        set_r('h2A, A_L, 0, 0);    set_r('h2B, A_LU, 0, 0);
        set_i('h00, C_R, 0);       set_i('h01, C_REGIMM, 0);
        set_i('h02, C_J, A_ADD);   set_i('h03, C_JAL, A_ADD);
        set_i('h04, C_BRANCH, A_EQ); set_i('h05, C_BRANCH, A_NEQ);
        set_i('h06, C_BRANCH, A_LE); set_i('h07, C_BRANCH, A_G);
        set_i('h08, C_ALUI_S, A_ADD); set_i('h09, C_ALUI_S, A_ADD);
        set_i('h0A, C_ALUI_S, A_L);   set_i('h0B, C_ALUI_S, A_LU);
        set_i('h0C, C_ALUI_Z, A_AND); set_i('h0D, C_ALUI_Z, A_OR);
        set_i('h0E, C_ALUI_Z, A_XOR); set_i('h0F, C_LUI, A_SL);
        foreach (legal_ops[k]) begin
            if (legal_ops[k] >= 'h20 && legal_ops[k] <= 'h25) set_i(legal_ops[k], C_LOAD, A_ADD);
            if (legal_ops[k] >= 'h28) set_i(legal_ops[k], C_STORE, A_ADD);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   op, fn, rt;
        op = int'(inst[31:26]); fn = int'(inst[5:0]); rt = int'(inst[20:16]);
        e.pc = pc; e.alu = 5'(A_ERR); e.ctrl = 10'(IL); e.rd = 5'd0; e.rd_known = 1'b0;
        case (i_cls[op])
            C_R: if (r_alu[fn] >= 0) begin
                e.alu = 5'(r_alu[fn]);
                e.ctrl = 10'((r_nw[fn] ? 0 : RW) | (r_sh[fn] ? SH : 0));
                e.rd = inst[15:11]; e.rd_known = 1'b1;
            end
            C_ALUI_S: begin e.alu = 5'(i_alu[op]); e.ctrl = 10'(UI | SX | RW); e.rd = inst[20:16]; e.rd_known = 1'b1; end
            C_ALUI_Z: begin e.alu = 5'(i_alu[op]); e.ctrl = 10'(UI | RW); e.rd = inst[20:16]; e.rd_known = 1'b1; end
            C_LUI:    begin e.alu = 5'(A_SL); e.ctrl = 10'(LU | UI | RW); e.rd = inst[20:16]; e.rd_known = 1'b1; end
            C_LOAD:   begin e.alu = 5'(A_ADD); e.ctrl = 10'(MR | RW | UI | SX); e.rd = inst[20:16]; e.rd_known = 1'b1; end
            C_STORE:  begin e.alu = 5'(A_ADD); e.ctrl = 10'(MW | UI | SX); end
            C_BRANCH: begin e.alu = 5'(i_alu[op]); e.ctrl = 10'(BR | SX); end
            C_REGIMM: if (rt < 2) begin e.alu = 5'(rt == 0 ? A_L : A_GE); e.ctrl = 10'(BR | SX); end
            C_J:      begin e.alu = 5'(A_ADD); e.ctrl = 10'(JP); end
            C_JAL:    begin e.alu = 5'(A_ADD); e.ctrl = 10'(JP | RW); e.rd = 5'd31; e.rd_known = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = 6'(legal_ops[$urandom_range(0, 22)]);
        if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0) w[5:0] = 6'(legal_fn[$urandom_range(0, 19)]);
        if (w[31:26] == 6'h01 && $urandom_range(0, 2) != 0) w[20:16] = 5'($urandom_range(0, 1));
        return w;
    endfunction

    task automatic compare_model();
        chk("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("model_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        if (mq.size() > 0) begin
            chk("model_out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("model_out_alu_op", 64'(out_alu_op), 64'(mq[0].alu));
            chk("model_out_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
            if (mq[0].rd_known) chk("model_out_rd", 64'(out_rd), 64'(mq[0].rd));
        end
    endtask

    // One clock: the model decides from pre-edge inputs, both update at the edge.
    task automatic cycle();
        bit do_push, do_pop;
        do_push = in_valid && (mq.size() < DEPTH) && !flush;
        do_pop  = (mq.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ref_decode(in_inst, in_pc));
        end
        #1;
        compare_model();
    endtask

    task automatic add_vec(input logic [31:0] inst, input int alu, input int ctrl, input int rd, input bit known);
        vec_t v;
        v.inst = inst; v.alu = 5'(alu); v.ctrl = 10'(ctrl); v.rd = 5'(rd); v.rd_known = known;
        vq.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        init_tables();

        add_vec(32'h20090005, A_ADD, UI | SX | RW, 9, 1);
        add_vec(32'h3C011234, A_SL, LU | UI | RW, 1, 1);
        add_vec(32'h04010003, A_GE, BR | SX, 0, 0);
        add_vec(32'h00000018, A_MULT, 0, 0, 1);
        add_vec(32'hFC000000, A_ERR, IL, 0, 0);
        add_vec(32'h012A4020, A_ADD, RW, 8, 1);
        add_vec(32'h00094080, A_SL, SH | RW, 8, 1);
        add_vec(32'h01294004, A_SL, RW, 8, 1);
        add_vec(32'h00094083, A_ASR, SH | RW, 8, 1);
        add_vec(32'h01294006, A_LSR, RW, 8, 1);
        add_vec(32'h8D280004, A_ADD, MR | RW | UI | SX, 8, 1);
        add_vec(32'hAD280004, A_ADD, MW | UI | SX, 0, 0);
        add_vec(32'h11280003, A_EQ, BR | SX, 0, 0);
        add_vec(32'h15280003, A_NEQ, BR | SX, 0, 0);
        add_vec(32'h19200003, A_LE, BR | SX, 0, 0);
        add_vec(32'h1D200003, A_G, BR | SX, 0, 0);
        add_vec(32'h05200003, A_L, BR | SX, 0, 0);
        add_vec(32'h05220003, A_ERR, IL, 0, 0);
        add_vec(32'h08000100, A_ADD, JP, 0, 0);
        add_vec(32'h0C000100, A_ADD, JP | RW, 31, 1);
        add_vec(32'h35280FF0, A_OR, UI | RW, 8, 1);
        add_vec(32'h2D280001, A_LU, UI | SX | RW, 8, 1);
        add_vec(32'h01200008, A_ERR, IL, 0, 0);
        add_vec(32'h0128001B, A_DIV, 0, 0, 1);
        add_vec(32'h012A4027, A_NOR, RW, 8, 1);
        add_vec(32'h012A402B, A_LU, RW, 8, 1);

        // Reset state, sampled between clock edges.
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_pc", 64'(out_pc), 64'd0);
        chk("reset_out_alu_op", 64'(out_alu_op), 64'd0);
        chk("reset_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("reset_out_rd", 64'(out_rd), 64'd0);
        $display("reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        rst_n = 1'b1;
        @(posedge clk); #1;
        compare_model();

        // Decode table: one push per cycle with the consumer always ready.
        out_ready = 1'b1;
        foreach (vq[i]) begin
            in_valid = 1'b1;
            in_inst  = vq[i].inst;
            in_pc    = (i == 0) ? 32'h400 : 32'h1000 + 32'(4 * i);
            cycle();
            chk("vec_out_valid", 64'(out_valid), 64'd1);
            chk("vec_out_pc", 64'(out_pc), 64'(in_pc));
            chk("vec_out_alu_op", 64'(out_alu_op), 64'(vq[i].alu));
            chk("vec_out_ctrl", 64'(out_ctrl), 64'(vq[i].ctrl));
            if (vq[i].rd_known) chk("vec_out_rd", 64'(out_rd), 64'(vq[i].rd));
            $display("vec %0d inst=0x%08h pc=0x%0h alu=%0d ctrl=0x%03h rd=%0d", i, in_inst, out_pc, out_alu_op, out_ctrl, out_rd);
        end
        in_valid = 1'b0;
        cycle();

        // Fill to full with the consumer stalled, then release it.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h20090005;
        in_pc = 32'h2000; cycle();
        chk("full_ready_after1", 64'(in_ready), 64'd1);
        in_pc = 32'h2004; cycle();
        chk("full_ready_after2", 64'(in_ready), 64'd0);
        in_pc = 32'h2008; cycle();
        chk("full_held_ready", 64'(in_ready), 64'd0);
        chk("full_head_stable", 64'(out_pc), 64'h2000);
        out_ready = 1'b1; cycle();
        chk("full_second_out", 64'(out_pc), 64'h2004);
        cycle();
        chk("full_third_out", 64'(out_pc), 64'h2008);
        in_valid = 1'b0; cycle();
        chk("full_drained", 64'(out_valid), 64'd0);
        $display("full sequence: drained out_valid=%0d", out_valid);

        // Simultaneous push and pop with one entry resident.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h012A4020; in_pc = 32'h2400; cycle();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_pc = 32'h2400 + 32'(4 * k);
            cycle();
            chk("pp_out_valid", 64'(out_valid), 64'd1);
            chk("pp_in_ready", 64'(in_ready), 64'd1);
            chk("pp_out_pc", 64'(out_pc), 64'(32'h2400 + 32'(4 * k)));
            $display("push+pop %0d: out_pc=0x%0h", k, out_pc);
        end
        in_valid = 1'b0; cycle();

        // Flush with two queued and a valid input present.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h8D280004;
        in_pc = 32'h2100; cycle();
        in_pc = 32'h2104; cycle();
        in_valid = 1'b1; in_pc = 32'hDEAD0000; flush = 1'b1; cycle();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; cycle();
        chk("flush_stays_empty", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_pc = 32'h2200; cycle();
        chk("flush_next_pc", 64'(out_pc), 64'h2200);
        in_valid = 1'b0; out_ready = 1'b1; cycle();
        $display("flush sequence: post-flush head pc=0x2200 checked");

        // Asynchronous reset with two entries queued, checked before any edge.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h3C011234;
        in_pc = 32'h2500; cycle();
        in_pc = 32'h2504; cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd1);
        chk("areset_out_pc", 64'(out_pc), 64'd0);
        mq.delete();
        $display("async reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        compare_model();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Parametrised successor to the combinational control decoder.
- Decodes full 32-bit MIPS32 instruction words into a complete control bundle: ALU op plus datapath/memory/branch/jump controls.
- Buffers each bundle in a DEPTH-entry queue with valid/ready handshakes on both sides, plus flush.
- Sits between IF and the ID/EX register. Decouples fetch from execute stalls.

Parameters:
- XLEN, 32, instruction and PC width
- ALUOP_WIDTH, 5, width of alu_op, from the shared defines header
- DEPTH, 2, queue entries, legal 1..4
- EN_JTYPE, 1, 1: J/JAL decoded. 0: J/JAL flagged illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all queued entries and the current input
- in_valid  in  1  in_inst/in_pc valid
- in_ready  out  1  queue can accept
- in_inst  in  XLEN  instruction word
- in_pc  in  XLEN  PC of in_inst, passed through
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_pc  out  XLEN  head PC
- out_alu_op  out  ALUOP_WIDTH  ALU operation code
- out_ctrl  out  10  {illegal, lui, shamt_sel, use_imm, imm_sext, jump, branch, mem_write, mem_read, reg_write}, bit 0 = reg_write
- out_rd  out  5  destination: rd (R), rt (I), 31 (JAL)

Behaviour:
- Reset (async, rst_n=0): queue empty; in_ready=1. out_valid=0. out_pc, out_alu_op, out_ctrl, out_rd = 0.
- Decode is combinational on in_inst. The bundle is written to the tail on accept (in_valid & in_ready & !flush).
- Latency: an entry accepted at edge N is visible on out_* after edge N, when the queue was empty. Minimum latency is 1 cycle.
- in_ready = (count < DEPTH). There is no combinational path from out_ready to in_ready.
- Pop on out_valid & out_ready & !flush. Push and pop in the same cycle: count unchanged, order preserved.
- out_* are driven from the head register. They hold stable while out_valid & !out_ready.
- flush=1: count becomes 0 at the next edge, pointers reset, and any simultaneous accept or pop is discarded. in_ready=1 the following cycle.
- Pointers wrap modulo DEPTH. Full state: count==DEPTH, in_ready=0.
- R-type (op 0), by funct:
  - ADD/ADDU→ALU_ADD; SUB/SUBU→ALU_SUB; MULT/MULTU→ALU_MULT; DIV/DIVU→ALU_DIV.
  - SLL/SLLV/SRA/SRAV/SRL/SRLV→ALU_SL/ALU_ARITH_SR/ALU_LOGIC_SR. shamt_sel=1 for SLL/SRA/SRL only.
  - AND/OR/XOR/NOR→corresponding op. SLT→ALU_L; SLTU→ALU_L_U.
  - reg_write=1, except MULT/MULTU/DIV/DIVU where reg_write=0.
- I-type, by opcode:
  - ADDI/ADDIU→ALU_ADD, imm_sext=1.
  - ANDI/ORI/XORI→logic op, imm_sext=0.
  - SLTI→ALU_L; SLTIU→ALU_L_U, both imm_sext=1.
  - LUI→ALU_SL with lui=1; the shift amount of 16 is implied by lui.
  - All of the above: use_imm=1, reg_write=1.
- Loads LW/LH/LHU/LB/LBU: ALU_ADD, mem_read=1, reg_write=1, use_imm=1, imm_sext=1.
- Stores SW/SH/SB: ALU_ADD, mem_write=1, use_imm=1, imm_sext=1.
- Branches, branch=1, imm_sext=1:
  - BEQ→ALU_EQ; BNE→ALU_NEQ; BLEZ→ALU_LE; BGTZ→ALU_G.
  - REGIMM with rt=0→ALU_L (BLTZ); rt=1→ALU_GE (BGEZ).
- J: jump=1. JAL: jump=1, reg_write=1, out_rd=31. alu_op=ALU_ADD for both.
- Any unlisted opcode, funct or REGIMM rt: illegal=1, alu_op=ALUOP_ERR, all other ctrl bits 0. The entry is still queued.

Test Plan:
- Reset mid-stream with 2 entries queued, rst_n low asynchronously → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- Push 0x20090005 (ADDI $9,$0,5) at pc 0x400 → next cycle out_valid=1, out_pc=0x400, out_alu_op=ALU_ADD, reg_write=use_imm=imm_sext=1, out_rd=9.
- DEPTH=2, out_ready=0, push 3 instructions → in_ready=0 after the 2nd accept; 3rd held. Release out_ready → entries emerge in order, 3rd accepted once count<2.
- Simultaneous push and pop at count=1 every cycle for 8 cycles → count stays 1, no drop or duplicate, PCs sequential.
- flush asserted with 2 queued and in_valid=1 → next cycle out_valid=0, count=0, flushed input never appears.
- Push 0x3C011234 (LUI), 0x04010003 (BGEZ), 0x00000018 (MULT), 0xFC000000 (undefined) → lui=1/ALU_SL; ALU_GE/branch=1; ALU_MULT/reg_write=0; illegal=1/ALUOP_ERR.
